// File: rtl/rv_pkg.sv
// Shared definitions for the bit-serial register file.
//   rf_op_t    : request opcode encoding (matches the req_op port bits)
//   rf_state_t : sequencer states
//   op_reads / op_writes : decode helpers for the opcode
package rv_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_RW    = 2'b11
  } rf_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } rf_state_t;

  function automatic logic op_reads(rf_op_t op);
    return (op == OP_READ) || (op == OP_RW);
  endfunction

  function automatic logic op_writes(rf_op_t op);
    return (op == OP_WRITE) || (op == OP_RW);
  endfunction

endpackage

// File: rtl/serial_reg_word.sv
// One rotating XLEN-bit storage word.
//   clk, rst  : clock / async active-high reset (clears the word)
//   shift_en  : rotate left by DIGIT_W this cycle
//   wr_en     : replace the digit rotated into the LSB with din
//   din       : DIGIT_W write digit
//   dout      : current top (MSB) digit, i.e. the digit about to rotate out
module serial_reg_word #(
  parameter int XLEN    = 32,
  parameter int DIGIT_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift_en,
  input  logic               wr_en,
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  logic [XLEN-1:0] q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (shift_en)
      q <= {q[XLEN-DIGIT_W-1:0], (wr_en ? din : q[XLEN-1 -: DIGIT_W])};
  end

  assign dout = q[XLEN-1 -: DIGIT_W];

endmodule

// File: rtl/serial_regfile_seq.sv
// Bit-serial register file with built-in shift sequencer.
// One accepted request rotates every word a full turn (N = XLEN/DIGIT_W
// cycles); reads collect the selected words MSB digit first, writes merge
// the latched wr_data into the rd word MSB digit first.
//   clk, rst           : clock / async active-high reset
//   req_valid/req_ready: request handshake (ready only while idle)
//   req_op             : NOP / READ / WRITE / RW
//   rs1_sel, rs2_sel   : read selects
//   rd_sel, wr_data    : write select and data
//   rs1_data, rs2_data : read results, valid from done until next accept
//   done               : one-cycle completion pulse
module serial_regfile_seq
  import rv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NREGS   = 16,
  parameter int DIGIT_W = 2,
  parameter int ZERO_R0 = 1,
  localparam int SEL_W  = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [SEL_W-1:0] rs1_sel,
  input  logic [SEL_W-1:0] rs2_sel,
  input  logic [SEL_W-1:0] rd_sel,
  input  logic [XLEN-1:0]  wr_data,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic             done
);

  localparam int N     = XLEN / DIGIT_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  rf_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt;
  rf_op_t           op_q;
  logic [SEL_W-1:0] rs1_q, rs2_q, rd_q;
  logic [XLEN-1:0]  wd_q;

  logic accept, shifting, last;
  logic [NREGS-1:0][DIGIT_W-1:0] dig;
  logic [DIGIT_W-1:0] rs1_dig, rs2_dig;

  assign req_ready = (state == S_IDLE);
  assign done      = (state == S_DONE);
  assign accept    = req_valid && req_ready;
  assign shifting  = (state == S_SHIFT);
  assign last      = (cnt == CNT_W'(N - 1));

  // A select reads as zero when it is out of range or is the hardwired r0.
  function automatic logic readable(logic [SEL_W-1:0] sel);
    return (32'(sel) < NREGS) && !((ZERO_R0 != 0) && (sel == '0));
  endfunction

  // Digits are sampled from the top of each word before this cycle's
  // rotation, so an RW to the same register returns the old value.
  assign rs1_dig = readable(rs1_q) ? dig[rs1_q] : '0;
  assign rs2_dig = readable(rs2_q) ? dig[rs2_q] : '0;

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    localparam bit HARD_ZERO = (ZERO_R0 != 0) && (i == 0);
    logic wr_en;
    assign wr_en = shifting && op_writes(op_q) && !HARD_ZERO &&
                   (rd_q == SEL_W'(i));
    serial_reg_word #(.XLEN(XLEN), .DIGIT_W(DIGIT_W)) u_word (
      .clk      (clk),
      .rst      (rst),
      .shift_en (shifting),
      .wr_en    (wr_en),
      .din      (wd_q[XLEN-1 -: DIGIT_W]),
      .dout     (dig[i])
    );
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = (rf_op_t'(req_op) == OP_NOP) ? S_DONE : S_SHIFT;
      S_SHIFT: if (last)   state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_q     <= OP_NOP;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      wd_q     <= '0;
      rs1_data <= '0;
      rs2_data <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q  <= rf_op_t'(req_op);
        rs1_q <= rs1_sel;
        rs2_q <= rs2_sel;
        rd_q  <= rd_sel;
        wd_q  <= wr_data;
        cnt   <= '0;
        if (op_reads(rf_op_t'(req_op))) begin
          rs1_data <= '0;
          rs2_data <= '0;
        end
      end else if (shifting) begin
        cnt  <= last ? '0 : cnt + 1'b1;
        wd_q <= wd_q << DIGIT_W;
        if (op_reads(op_q)) begin
          rs1_data <= {rs1_data[XLEN-DIGIT_W-1:0], rs1_dig};
          rs2_data <= {rs2_data[XLEN-DIGIT_W-1:0], rs2_dig};
        end
      end
    end
  end

endmodule
